// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Multi-port register file with jump-and-link write redirect and a
//            per-register busy scoreboard for RAW hazard stalls in decode.
//            Optional macro REGFILE_BYPASS_EN adds write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_RD   = 2,
    parameter  int LINK_REG = 31,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     stall,
    input  logic                     wr_en,
    input  logic                     JumpAndLink,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W-1:0]        link_addr,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     flush
);

    localparam logic [ADDR_W-1:0] c_link_idx = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    logic                w_wr_act;
    logic [ADDR_W-1:0]   w_wr_idx;
    logic [DATA_W-1:0]   w_wr_val;

    // Jump-and-link overrides the writeback address and data entirely.
    always_comb begin
        w_wr_idx = JumpAndLink ? c_link_idx : wr_addr;
        w_wr_val = JumpAndLink ? link_addr  : wr_data;
        w_wr_act = wr_en && (w_wr_idx != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_act) begin
            r_regs[w_wr_idx] <= w_wr_val;
        end
    end

    // Issue set is applied after the writeback clear so a younger producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_act) begin
            w_busy_nxt[w_wr_idx] = 1'b0;
        end
        if (flush) begin
            w_busy_nxt = '0;
        end else if (issue_en && (issue_addr != '0)) begin
            w_busy_nxt[issue_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_stored;
            logic              w_busy_stored;

            assign w_addr        = rd_addr[gi*ADDR_W +: ADDR_W];
            assign w_stored      = (w_addr == '0) ? '0 : r_regs[w_addr];
            assign w_busy_stored = (w_addr == '0) ? 1'b0 : r_busy[w_addr];

`ifdef REGFILE_BYPASS_EN
            logic w_hit;
            assign w_hit = w_wr_act && (w_wr_idx == w_addr);
            assign rd_data[gi*DATA_W +: DATA_W] = w_hit ? w_wr_val : w_stored;
            assign rd_busy[gi]                  = w_hit ? 1'b0 : w_busy_stored;
`else
            assign rd_data[gi*DATA_W +: DATA_W] = w_stored;
            assign rd_busy[gi]                  = w_busy_stored;
`endif
        end
    endgenerate

    assign stall = |(rd_valid & rd_busy);

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Self-checking bench for regfile_scoreboard against a behavioural
//            array model; directed scenarios followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int RP = 2;
    localparam int AW = 5;
    localparam int LR = 31;

    logic              clk = 1'b0;
    logic              rst;
    logic [RP*AW-1:0]  rd_addr;
    logic [RP-1:0]     rd_valid;
    logic [RP*DW-1:0]  rd_data;
    logic [RP-1:0]     rd_busy;
    logic              stall;
    logic              wr_en;
    logic              JumpAndLink;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [DW-1:0]     link_addr;
    logic              issue_en;
    logic [AW-1:0]     issue_addr;
    logic              flush;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];

    regfile_scoreboard #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .NUM_RD   (RP),
        .LINK_REG (LR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .stall       (stall),
        .wr_en       (wr_en),
        .JumpAndLink (JumpAndLink),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .link_addr   (link_addr),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Which register (if any) the current inputs would write, and with what.
    task automatic model_target(output bit act, output int idx, output logic [DW-1:0] val);
        act = 1'b0;
        idx = 0;
        val = '0;
        if (wr_en && JumpAndLink) begin
            act = 1'b1;
            idx = LR;
            val = link_addr;
        end else if (wr_en && wr_addr != 0) begin
            act = 1'b1;
            idx = int'(wr_addr);
            val = wr_data;
        end
    endtask

    task automatic check_outputs();
        bit            act;
        int            idx;
        logic [DW-1:0] val;
        bit            exp_stall = 1'b0;
        model_target(act, idx, val);
        for (int p = 0; p < RP; p++) begin
            int            a = int'(rd_addr[p*AW +: AW]);
            logic [DW-1:0] ed = (a == 0) ? '0 : m_regs[a];
            bit            eb = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
            if (rst && act && idx == a && a != 0) begin
                ed = val;
                eb = 1'b0;
            end
`endif
            check_val($sformatf("rd_data%0d(r%0d)", p, a), 64'(rd_data[p*DW +: DW]), 64'(ed));
            check_val($sformatf("rd_busy%0d(r%0d)", p, a), 64'(rd_busy[p]), 64'(eb));
            if (rd_valid[p] && eb) exp_stall = 1'b1;
        end
        check_val("stall", 64'(stall), 64'(exp_stall));
    endtask

    task automatic model_update();
        bit            act;
        int            idx;
        logic [DW-1:0] val;
        if (!rst) begin
            model_clear();
            return;
        end
        model_target(act, idx, val);
        if (act) begin
            m_regs[idx] = val;
            m_busy[idx] = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        end else if (issue_en && issue_addr != 0) begin
            m_busy[int'(issue_addr)] = 1'b1;
        end
    endtask

    // Inputs are set just after a falling edge; outputs checked before the rising edge.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 1'b0; JumpAndLink = 1'b0; wr_addr = '0; wr_data = '0; link_addr = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a, input bit v);
        rd_addr[p*AW +: AW] = AW'(a);
        rd_valid[p]         = v;
    endtask

    initial begin
        rst = 1'b0;
        rd_addr = '0;
        rd_valid = '0;
        idle();
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check_val("reset_stall", 64'(stall), 64'(0));
        check_val("reset_data", 64'(rd_data), 64'(0));
        rst = 1'b1;

        // Basic write and r0 protection
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; step();
        wr_addr = 5'd0; wr_data = 32'h1234; set_rd(0, 5, 1'b1); set_rd(1, 0, 1'b1); step();
        idle(); #1;
        check_val("r5_write", 64'(rd_data[0 +: DW]), 64'h0000_0000_DEAD_BEEF);
        check_val("r0_zero", 64'(rd_data[DW +: DW]), 64'(0));
        step();

        // Jump-and-link: r7 pre-loaded, then redirected write to r31
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0777; step();
        JumpAndLink = 1'b1; link_addr = 32'h0040_0010; wr_data = 32'hFFFF_FFFF; step();
        idle(); set_rd(0, 31, 1'b0); set_rd(1, 7, 1'b0); #1;
        check_val("jal_r31", 64'(rd_data[0 +: DW]), 64'h0040_0010);
        check_val("jal_r7", 64'(rd_data[DW +: DW]), 64'h0777);
        step();

        // Scoreboard: issue, stall, writeback clear, same-cycle issue+writeback
        issue_en = 1'b1; issue_addr = 5'd9; step();
        idle(); set_rd(1, 9, 1'b1); #1;
        check_val("busy_r9", 64'(rd_busy[1]), 64'(1));
        check_val("stall_r9", 64'(stall), 64'(1));
        set_rd(1, 9, 1'b0); #1;
        check_val("stall_novalid", 64'(stall), 64'(0));
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; step();
        idle(); #1;
        check_val("r9_cleared", 64'(rd_busy[1]), 64'(0));
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h98; issue_en = 1'b1; issue_addr = 5'd9; step();
        idle(); #1;
        check_val("r9_set_wins", 64'(rd_busy[1]), 64'(1));
        step();

        // Flush with a same-cycle issue
        for (int r = 3; r <= 5; r++) begin
            issue_en = 1'b1; issue_addr = AW'(r); step();
        end
        flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd6; step();
        idle();
        for (int r = 3; r <= 9; r++) begin
            set_rd(0, r, 1'b1); #1;
            check_val($sformatf("flush_r%0d", r), 64'(rd_busy[0]), 64'(0));
        end
        step();

        // Same-cycle write to a busy register being read
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0000_0A0A; step();
        idle(); issue_en = 1'b1; issue_addr = 5'd10; step();
        idle(); wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hCAFE_0001; set_rd(0, 10, 1'b1); #1;
`ifdef REGFILE_BYPASS_EN
        check_val("byp_data", 64'(rd_data[0 +: DW]), 64'hCAFE_0001);
        check_val("byp_busy", 64'(rd_busy[0]), 64'(0));
`else
        check_val("nobyp_data", 64'(rd_data[0 +: DW]), 64'h0A0A);
        check_val("nobyp_busy", 64'(rd_busy[0]), 64'(1));
`endif
        step();

        // Random traffic, addresses biased low to provoke collisions
        for (int n = 0; n < 400; n++) begin
            wr_en       = ($urandom_range(0, 2) != 0);
            JumpAndLink = ($urandom_range(0, 7) == 0);
            wr_addr     = AW'($urandom_range(0, 11));
            wr_data     = $urandom;
            link_addr   = $urandom;
            issue_en    = ($urandom_range(0, 1) == 1);
            issue_addr  = AW'($urandom_range(0, 11));
            flush       = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < RP; p++) begin
                set_rd(p, ($urandom_range(0, 3) == 0) ? LR : $urandom_range(0, 11),
                       $urandom_range(0, 1) == 1);
            end
            step();
        end

        // Asynchronous reset mid-run after writes
        idle(); set_rd(0, 5, 1'b1); set_rd(1, 31, 1'b1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h5555_5555; issue_en = 1'b1; issue_addr = 5'd31; step();
        idle(); #2;
        rst = 1'b0;
        model_clear();
        #1;
        check_val("rst_data", 64'(rd_data), 64'(0));
        check_val("rst_busy", 64'(rd_busy), 64'(0));
        check_val("rst_stall", 64'(stall), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_r5", 64'(rd_data[0 +: DW]), 64'(0));
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
